// File: rtl/digit_template_matcher.sv
// rtl/digit_template_matcher.sv - scores a 16x16 drawn image against digit templates and reports the best match
module digit_template_matcher #(
  parameter int NUM_DIGITS   = 10,
  parameter int MATCH_THRESH = 200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [0:15] img_row,
  input  logic [0:15] tmpl_row,
  output logic [3:0]  row_addr,
  output logic [3:0]  digit_sel,
  output logic        busy,
  output logic        done,
  output logic [3:0]  result_digit,
  output logic [8:0]  result_score,
  output logic        result_valid
);

  localparam logic [3:0] LAST_DIGIT = 4'(NUM_DIGITS - 1);
  localparam logic [8:0] THRESH     = 9'(MATCH_THRESH);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_FINISH} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_row_addr;
  logic [3:0]  r_digit_sel;
  logic [8:0]  r_acc;
  logic [8:0]  r_best_score;
  logic [3:0]  r_best_digit;
  logic        r_busy;
  logic        r_done;
  logic [3:0]  r_result_digit;
  logic [8:0]  r_result_score;
  logic        r_result_valid;

  logic [15:0] w_xnor;
  logic [4:0]  w_row_match;
  logic [8:0]  w_digit_total;
  logic        w_last_row;
  logic        w_last_digit;
  logic        w_take_best;

  assign w_xnor        = ~(img_row ^ tmpl_row);
  assign w_digit_total = r_acc + 9'(w_row_match);
  assign w_last_row    = (r_row_addr == 4'd15);
  assign w_last_digit  = (r_digit_sel == LAST_DIGIT);
  // Digit 0 always seeds the best; later digits must strictly beat it so ties keep the lower digit.
  assign w_take_best   = (r_digit_sel == 4'd0) || (w_digit_total > r_best_score);

  // Count pixels where the drawn row agrees with the template row.
  always_comb begin
    w_row_match = '0;
    for (int i = 0; i < 16; i++) begin
      w_row_match = w_row_match + 5'(w_xnor[i]);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic: start only matters in IDLE; FINISH lasts exactly one cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_nxt = S_SCAN;
      S_SCAN:   if (w_last_row && w_last_digit) w_state_nxt = S_FINISH;
      S_FINISH: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Scan datapath: row/digit walk, per-digit accumulation, best tracking and result publication.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row_addr     <= '0;
      r_digit_sel    <= '0;
      r_acc          <= '0;
      r_best_score   <= '0;
      r_best_digit   <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_result_digit <= '0;
      r_result_score <= '0;
      r_result_valid <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_row_addr   <= '0;
            r_digit_sel  <= '0;
            r_acc        <= '0;
            r_best_score <= '0;
            r_best_digit <= '0;
            r_busy       <= 1'b1;
          end
        end
        S_SCAN: begin
          if (w_last_row) begin
            r_acc      <= '0;
            r_row_addr <= '0;
            if (w_take_best) begin
              r_best_score <= w_digit_total;
              r_best_digit <= r_digit_sel;
            end
            if (!w_last_digit) r_digit_sel <= r_digit_sel + 4'd1;
          end else begin
            r_acc      <= w_digit_total;
            r_row_addr <= r_row_addr + 4'd1;
          end
        end
        S_FINISH: begin
          r_result_digit <= r_best_digit;
          r_result_score <= r_best_score;
          r_result_valid <= (r_best_score >= THRESH);
          r_done         <= 1'b1;
          r_busy         <= 1'b0;
          r_digit_sel    <= '0;
        end
        default: begin
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign row_addr     = r_row_addr;
  assign digit_sel    = r_digit_sel;
  assign busy         = r_busy;
  assign done         = r_done;
  assign result_digit = r_result_digit;
  assign result_score = r_result_score;
  assign result_valid = r_result_valid;

endmodule

// File: tb/tb_digit_template_matcher.sv
// tb/tb_digit_template_matcher.sv - directed table-driven bench for digit_template_matcher
module tb_digit_template_matcher;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [0:15] img_row;
  logic [0:15] tmpl_row;
  logic [3:0]  row_addr;
  logic [3:0]  digit_sel;
  logic        busy;
  logic        done;
  logic [3:0]  result_digit;
  logic [8:0]  result_score;
  logic        result_valid;

  int n_cmp = 0;
  int n_bad = 0;
  int mode  = 0;

  digit_template_matcher dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .img_row      (img_row),
    .tmpl_row     (tmpl_row),
    .row_addr     (row_addr),
    .digit_sel    (digit_sel),
    .busy         (busy),
    .done         (done),
    .result_digit (result_digit),
    .result_score (result_score),
    .result_valid (result_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Distinct synthetic bitmap per digit: every row differs between any two digits.
  function automatic logic [15:0] synth(input int d, input int r);
    logic [3:0] dd;
    logic [3:0] rr;
    dd = 4'(d);
    rr = 4'(r);
    return {dd, rr, ~dd, ~rr};
  endfunction

  // Template ROM stub, selected by the current test mode.
  function automatic logic [15:0] tmpl_f(input int m, input int d, input int r);
    case (m)
      0: return (d == 3) ? 16'h0000 : 16'hFFFF;
      1: return synth(d, r);
      2: return (r % 2 == 0) ? 16'hAAAA : 16'h5555;
      3: return 16'h0000;
      4: return (d == 5) ? ((r < 7) ? 16'h00FF : 16'h0000) : 16'hFFFF;
      5: return (d == 5) ? ((r < 7) ? 16'h00FF : (r == 7) ? 16'h0001 : 16'h0000) : 16'hFFFF;
      6: return (d == 2 || d == 7) ? ((r == 0) ? 16'hFFFF : 16'h0000) : 16'hFFFF;
      default: return 16'h0000;
    endcase
  endfunction

  // Drawn-image buffer stub.
  function automatic logic [15:0] img_f(input int m, input int r);
    case (m)
      1:       return synth(8, r);
      2, 3:    return 16'hFFFF;
      default: return 16'h0000;
    endcase
  endfunction

  always_comb begin
    tmpl_row = tmpl_f(mode, int'(digit_sel), int'(row_addr));
    img_row  = img_f(mode, int'(row_addr));
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Runs one scan. Positioned at a negedge; if pulse_start=0 the start was already taken at the last edge.
  // chain=1 raises start while done is high so the next scan begins immediately.
  task automatic run_scan(input string name, input int exp_d, input int exp_s, input int exp_v,
                          input bit pulse_start, input bit chain, input bit repulse);
    int done_at;
    int walk_err;
    done_at  = -1;
    walk_err = 0;
    if (pulse_start) begin
      start = 1'b1;
      @(negedge clk);
    end
    start = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (done) begin
        done_at = n;
        break;
      end
      if (n < 160) begin
        if (row_addr !== 4'(n % 16) || digit_sel !== 4'(n / 16) || busy !== 1'b1) walk_err++;
      end
      start = repulse && (n == 5 || n == 100);
      @(negedge clk);
      start = 1'b0;
    end
    chk({name, " done_latency"}, done_at, 161);
    chk({name, " walk"}, walk_err, 0);
    chk({name, " result_digit"}, int'(result_digit), exp_d);
    chk({name, " result_score"}, int'(result_score), exp_s);
    chk({name, " result_valid"}, int'(result_valid), exp_v);
    chk({name, " busy_at_done"}, int'(busy), 0);
    if (chain) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({name, " done_one_cycle"}, int'(done), 0);
    chk({name, " results_hold"}, int'(result_score), exp_s);
  endtask

  typedef struct {
    string name;
    int    m;
    int    exp_d;
    int    exp_s;
    int    exp_v;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{"digit3_zero",    0, 3, 256, 1};
    vecs[1] = '{"exact_digit8",   1, 8, 256, 1};
    vecs[2] = '{"tie_checker",    2, 0, 128, 0};
    vecs[3] = '{"all_miss",       3, 0,   0, 0};
    vecs[4] = '{"thresh_equal",   4, 5, 200, 1};
    vecs[5] = '{"thresh_below",   5, 5, 199, 0};
    vecs[6] = '{"tie_2_7",        6, 2, 240, 1};

    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset row_addr", int'(row_addr), 0);
    chk("reset digit_sel", int'(digit_sel), 0);
    chk("reset result", int'({result_digit, result_score, result_valid}), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle no busy", int'(busy), 0);

    for (int i = 0; i < 7; i++) begin
      mode = vecs[i].m;
      run_scan(vecs[i].name, vecs[i].exp_d, vecs[i].exp_s, vecs[i].exp_v, 1'b1, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
    end

    // Start re-pulsed mid-scan is ignored; start while done is high begins a fresh scan.
    mode = 0;
    run_scan("repulse", 3, 256, 1, 1'b1, 1'b1, 1'b1);
    mode = 1;
    run_scan("chained", 8, 256, 1, 1'b0, 1'b0, 1'b0);

    // Reset mid-scan aborts at once and clears previous results.
    mode = 6;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (80) @(negedge clk);
    chk("midscan busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("abort busy", int'(busy), 0);
    chk("abort row_addr", int'(row_addr), 0);
    chk("abort digit_sel", int'(digit_sel), 0);
    chk("abort result_digit", int'(result_digit), 0);
    chk("abort result_score", int'(result_score), 0);
    chk("abort result_valid", int'(result_valid), 0);
    begin
      int seen_done;
      seen_done = 0;
      repeat (3) begin
        @(negedge clk);
        if (done) seen_done++;
      end
      rst_n = 1'b1;
      repeat (200) begin
        @(negedge clk);
        if (done) seen_done++;
      end
      chk("abort no_done", seen_done, 0);
    end
    chk("abort idle busy", int'(busy), 0);
    mode = 1;
    run_scan("after_reset", 8, 256, 1, 1'b1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/digit_template_matcher.md
Name: digit_template_matcher

Overview:
- Downstream consumer of the per-digit 16x16 bitmap ROMs (prom_0 … prom_9) in the Basys3 number-recognition design.
- On a start pulse, scans all 10 digit templates row by row and compares each row against the user-drawn 16x16 image.
- Per digit, scores the number of matching pixels (XNOR popcount) and reports the best-matching digit, its score and a confidence flag to the display/control logic.
- Drives the comparison-port address of the ROMs plus an external digit-select mux; the ROM display port is unaffected.

Parameters:
- NUM_DIGITS, 10, number of templates scanned (digits 0..NUM_DIGITS-1, max 16).
- MATCH_THRESH, 200, minimum best score (0..256) for result_valid=1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a scan; ignored while busy
- img_row  in  [0:15]  drawn-image row at row_addr, combinational from image buffer; bit 0 = leftmost pixel
- tmpl_row  in  [0:15]  template row (ROM Char output) for digit_sel/row_addr, combinational
- row_addr  out  4  row index to image buffer and ROM addr port
- digit_sel  out  4  template select to external ROM mux
- busy  out  1  high during scan
- done  out  1  one-cycle pulse when results update
- result_digit  out  4  best-matching digit
- result_score  out  9  matching-pixel count of best digit, 0..256
- result_valid  out  1  result_score >= MATCH_THRESH

Behaviour:
- Reset (async, rst_n=0): state IDLE; row_addr=0, digit_sel=0, busy=0, done=0, result_digit=0, result_score=0, result_valid=0, accumulator and best registers cleared.
- FSM states: IDLE, SCAN, FINISH.
- IDLE: start=1 at an edge -> SCAN. row_addr=0, digit_sel=0, acc=0, best_score=0, best_digit=0, busy=1.
- SCAN: one row per cycle.
  - row_match = popcount(~(img_row ^ tmpl_row)), 0..16, sampled at the clock edge.
  - row_addr<15: acc += row_match; row_addr++.
  - row_addr=15: digit_total = acc + row_match (9 bits, no overflow). If digit_total > best_score (strict), best_score<=digit_total and best_digit<=digit_sel.
  - Ties keep the lower digit. Digit 0 always loads because best starts at 0, with strict > against 0 overridden: digit 0 loads unconditionally.
  - At row_addr=15: acc<=0, row_addr<=0 (wrap). If digit_sel=NUM_DIGITS-1 -> FINISH, else digit_sel++.
- FINISH (one cycle): result_digit<=best_digit, result_score<=best_score (final value, including last-digit update), result_valid<=(best_score>=MATCH_THRESH), done=1, busy=0, digit_sel<=0 -> IDLE.
- Latency: start sampled at edge E0; SCAN occupies 16*NUM_DIGITS cycles (160); done high in the cycle after edge E161; results stable from then until the next FINISH.
- start during SCAN/FINISH: ignored, not queued. start in the same cycle as done: accepted only if state is IDLE (FINISH ignores it).
- Reset mid-scan: immediate abort to reset values; no done pulse; previous results cleared.
- img_row/tmpl_row must be stable within the cycle; the block adds no input registers. row_addr/digit_sel are registered outputs (glitch-free).
- Outputs hold while IDLE; done never high for more than one cycle.

Test Plan:
- Stub ROMs: digit 3 all-zero rows, other digits all-ones; image all zeros; pulse start -> after 161 cycles done=1, result_digit=3, result_score=256, result_valid=1, busy low.
- Real prom_0..prom_9; image = exact digit-8 bitmap -> result_digit=8, result_score=256, result_valid=1. Check row_addr walks 0..15 per digit and digit_sel 0..9.
- All templates identical (checkerboard), image all ones -> tie at score 128; result_digit=0, result_score=128, result_valid=0.
- Image all ones, all templates all zeros -> result_score=0, result_digit=0, result_valid=0.
- start re-pulsed at cycles 5 and 100 of a scan -> no restart; done exactly once at cycle 161. start the cycle after done -> new scan runs normally.
- rst_n low at cycle 80 of a scan -> all outputs immediately 0, no done. After release, start -> full correct scan.
